// File: rtl/state_timer_bank_pkg.sv
// Shared types and constants for the per-state timer bank: FSM encoding,
// default widths and the train controller state codes used to index presets.
package state_timer_bank_pkg;

  localparam int DEF_TW = 19;
  localparam int DEF_SW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } tmr_state_e;

  // Train controller state codes; presets are indexed by these.
  localparam logic [3:0] ST_RESET  = 4'b0000;
  localparam logic [3:0] ST_RED    = 4'b0001;
  localparam logic [3:0] ST_GREEN  = 4'b0010;
  localparam logic [3:0] ST_YELLOW = 4'b0011;
  localparam logic [3:0] ST_STOP   = 4'b0100;
  localparam logic [3:0] ST_DEPART = 4'b0101;

endpackage

// File: rtl/state_timer_bank_if.sv
// Controller <-> timer bank connection: state, preset table and tick in,
// remaining count, busy and expire pulse out.
interface state_timer_bank_if #(
  parameter int TW = state_timer_bank_pkg::DEF_TW,
  parameter int SW = state_timer_bank_pkg::DEF_SW
);
  localparam int NS = 1 << SW;

  logic [SW-1:0]    present_state;
  logic [NS*TW-1:0] preset_flat;
  logic             tick;
  logic [TW-1:0]    tout;
  logic             busy;
  logic             expire;

  modport master (
    output present_state, preset_flat, tick,
    input  tout, busy, expire
  );

  modport slave (
    input  present_state, preset_flat, tick,
    output tout, busy, expire
  );
endinterface

// File: rtl/state_timer_bank_mux.sv
// Combinational NS:1 preset selector: picks the TW-bit slice of the flat
// preset table belonging to the selected state.
module state_timer_mux #(
  parameter int TW = 19,
  parameter int SW = 4
) (
  input  logic [(1<<SW)*TW-1:0] preset_flat,
  input  logic [SW-1:0]         sel,
  output logic [TW-1:0]         preset
);
  localparam int NS = 1 << SW;

  logic [TW-1:0] table_arr [NS];

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slice
      assign table_arr[gi] = preset_flat[gi*TW +: TW];
    end
  endgenerate

  assign preset = table_arr[sel];
endmodule

// File: rtl/state_timer_bank.sv
// Per-state down-counter: loads the preset of each newly entered state and
// counts it down on tick. Define STATE_TIMER_BANK_RELOAD_EN for periodic expire.
module state_timer_bank
  import state_timer_bank_pkg::*;
#(
  parameter int TW = DEF_TW,
  parameter int SW = DEF_SW
) (
  input  logic                clk,
  input  logic                rst_n,
  state_timer_bank_if.slave   bus
);
  logic [TW-1:0] preset_sel;
  logic [TW-1:0] tout_q;
  logic          busy_q;
  logic          expire_q;
  logic [SW-1:0] prev_state_q;
  logic          first_q;
  tmr_state_e    state_q;
  logic          chg;

  state_timer_mux #(.TW(TW), .SW(SW)) u_mux (
    .preset_flat (bus.preset_flat),
    .sel         (bus.present_state),
    .preset      (preset_sel)
  );

  // The first cycle after reset counts as a state change so the current
  // state's preset is always loaded.
  assign chg = first_q | (bus.present_state != prev_state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tout_q       <= '0;
      busy_q       <= 1'b0;
      expire_q     <= 1'b0;
      prev_state_q <= '0;
      first_q      <= 1'b1;
    end else begin
      prev_state_q <= bus.present_state;
      first_q      <= 1'b0;
      expire_q     <= 1'b0;
      if (chg) begin
        // A load overrides any terminal tick landing in the same cycle.
        tout_q <= preset_sel;
        if (preset_sel != '0) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end else begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (bus.tick) begin
              if (tout_q > TW'(1)) begin
                tout_q <= tout_q - TW'(1);
              end else begin
                expire_q <= 1'b1;
`ifdef STATE_TIMER_BANK_RELOAD_EN
                // Periodic mode: restart from the live table entry.
                tout_q <= preset_sel;
                if (preset_sel != '0) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
`else
                tout_q  <= '0;
                state_q <= EXPIRED;
                busy_q  <= 1'b0;
`endif
              end
            end
          end
          default: begin
            tout_q <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tout   = tout_q;
  assign bus.busy   = busy_q;
  assign bus.expire = expire_q;
endmodule

// File: tb/tb_state_timer_bank.sv
// Randomized self-checking bench for state_timer_bank against a behavioural
// remaining-ticks model; honours STATE_TIMER_BANK_RELOAD_EN when defined.
module tb_state_timer_bank;
  import state_timer_bank_pkg::*;

  localparam int TW = DEF_TW;
  localparam int SW = DEF_SW;
  localparam int NS = 1 << SW;
  localparam int MAXV = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  state_timer_bank_if #(.TW(TW), .SW(SW)) bus();

  state_timer_bank #(.TW(TW), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int presets [NS];

  // Reference model: remaining ticks, whether a count is live, expire flag.
  int m_remaining;
  bit m_counting;
  bit m_expire;
  bit m_first;
  int m_prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pack_presets();
    for (int s = 0; s < NS; s++) bus.preset_flat[s*TW +: TW] = TW'(presets[s]);
  endtask

  task automatic model_reset();
    m_remaining = 0;
    m_counting  = 1'b0;
    m_expire    = 1'b0;
    m_first     = 1'b1;
    m_prev      = 0;
  endtask

  task automatic model_clock();
    int  ps;
    int  p;
    ps = int'(bus.present_state);
    p  = presets[ps];
    m_expire = 1'b0;
    if (m_first || ps != m_prev) begin
      m_remaining = p;
      m_counting  = (p != 0);
    end else if (m_counting && bus.tick) begin
      if (m_remaining > 1) begin
        m_remaining = m_remaining - 1;
      end else begin
        m_expire = 1'b1;
`ifdef STATE_TIMER_BANK_RELOAD_EN
        m_remaining = p;
        m_counting  = (p != 0);
`else
        m_remaining = 0;
        m_counting  = 1'b0;
`endif
      end
    end
    m_prev  = ps;
    m_first = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_tout"},   32'(bus.tout),   32'(m_remaining));
    chk({tag, "_busy"},   32'(bus.busy),   32'(m_counting));
    chk({tag, "_expire"}, 32'(bus.expire), 32'(m_expire));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_clock();
    #1;
    cyc++;
    $display("[TB] cyc %0d %s ps=%0d tick=%0b tout=%0d busy=%0b expire=%0b",
             cyc, tag, bus.present_state, bus.tick, bus.tout, bus.busy, bus.expire);
    check_outputs(tag);
  endtask

  // Reset asserted between edges: outputs must drop before any clock edge.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, "_async"});
    step({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n_exp;
  int exp_reload;

  initial begin
    for (int s = 0; s < NS; s++) presets[s] = 0;
    presets[ST_GREEN]  = 5;
    presets[ST_YELLOW] = 7;
    presets[ST_STOP]   = 2;
    presets[ST_DEPART] = 3;
    presets[6]         = 2;
    presets[7]         = 12;
    presets[15]        = MAXV;
    pack_presets();
    bus.present_state = ST_GREEN;
    bus.tick          = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check_outputs("reset");

    // Release with green timed at 5 and a tick every cycle.
    rst_n    = 1'b1;
    bus.tick = 1'b1;
    step("green_load");
    chk("green_load_val", 32'(bus.tout), 32'd5);
    for (int i = 0; i < 5; i++) step("green_count");
    chk("green_final_tout", 32'(bus.tout), 32'd0);

    // Switch green -> yellow mid-count: the new preset appears next cycle.
    bus.present_state = ST_GREEN;
    presets[ST_GREEN] = 5;
    bus.present_state = ST_RED;
    step("to_red");
    bus.present_state = ST_GREEN;
    step("green_again");
    step("green_4");
    step("green_3");
    bus.present_state = ST_YELLOW;
    step("to_yellow");
    chk("yellow_load_val", 32'(bus.tout), 32'd7);
    chk("yellow_no_expire", 32'(bus.expire), 32'd0);
    for (int i = 0; i < 8; i++) step("yellow_count");

    // Untimed state: ticks must never expire.
    bus.present_state = ST_RESET;
    for (int i = 0; i < 20; i++) step("untimed");

    // State change coinciding with the terminal tick of the previous state.
    bus.present_state = 4'd6;
    step("s6_load");
    step("s6_one");
    bus.present_state = ST_STOP;
    step("collide");
    chk("collide_tout", 32'(bus.tout), 32'd2);
    chk("collide_expire", 32'(bus.expire), 32'd0);

    // Reset in the middle of a count, then reload of the current state.
    bus.present_state = 4'd7;
    step("s7_load");
    for (int i = 0; i < 3; i++) step("s7_count");
    chk("s7_tout_9", 32'(bus.tout), 32'd9);
    reset_pulse("midrst");
    step("midrst_reload");
    chk("midrst_reload_val", 32'(bus.tout), 32'd12);

    // Full-scale preset is accepted.
    bus.present_state = 4'd15;
    step("max_load");
    chk("max_load_val", 32'(bus.tout), 32'(MAXV));

    // Nine ticks in the depart state (preset 3).
    bus.present_state = ST_DEPART;
    step("depart_load");
    n_exp = 0;
    for (int i = 0; i < 9; i++) begin
      step("depart_tick");
      if (bus.expire) n_exp++;
    end
`ifdef STATE_TIMER_BANK_RELOAD_EN
    exp_reload = 3;
`else
    exp_reload = 1;
`endif
    chk("depart_expire_count", 32'(n_exp), 32'(exp_reload));

    // Randomized phase: state hops, sparse ticks, table rewrites, resets.
    for (int s = 0; s < NS; s++) begin
      if (s != 15) presets[s] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
    end
    pack_presets();
    for (int i = 0; i < 800; i++) begin
      bus.tick = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) bus.present_state = SW'($urandom_range(0, NS - 1));
      if ($urandom_range(0, 29) == 0) begin
        presets[$urandom_range(0, NS - 2)] = int'($urandom_range(0, 6));
        pack_presets();
      end
      if ($urandom_range(0, 199) == 0) reset_pulse("rnd_rst");
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
